// File: rtl/ov7725_ddr_wr_pack.sv
// OV7725 write-side packer: gathers 8 RGB565 pixels into one 128-bit DDR FIFO
// word, generates per-word pixel addresses in ping-pong frame banks, and
// flags FIFO overflow and short frames.
module ov7725_ddr_wr_pack #(
  parameter int                H_PIX      = 640,
  parameter int                V_LINE     = 480,
  parameter int                ADDR_W     = 28,
  parameter logic [ADDR_W-1:0] BANK0_BASE = 28'h000_0000,
  parameter logic [ADDR_W-1:0] BANK1_BASE = 28'h005_0000
) (
  input  logic              ov7725_pclk,
  input  logic              sys_rst_n,
  input  logic              ov7725_vsync,
  input  logic              pix_wr_en,
  input  logic [15:0]       pix_data,
  input  logic              fifo_full,
  input  logic              err_clr,
  output logic              fifo_wr_en,
  output logic [127:0]      fifo_wr_data,
  output logic [ADDR_W-1:0] fifo_wr_addr,
  output logic              frame_done,
  output logic              rd_bank,
  output logic              err_overflow,
  output logic              err_short_frame
);

  localparam int FRAME_PIX = H_PIX * V_LINE;
  localparam int PIX_W     = $clog2(FRAME_PIX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                vsync_d1;
  logic                wr_bank;
  logic [2:0]          lane_cnt;
  logic [PIX_W-1:0]    pix_cnt;
  logic [ADDR_W-4:0]   word_cnt;
  logic [127:0]        word_p0;

  logic                vs_rise;
  logic                pix_vld_p0;
  logic                word_vld_p0;
  logic                frame_last_p0;
  logic [ADDR_W-1:0]   base_addr;

  // A vsync edge takes priority over a coincident pixel strobe.
  assign vs_rise       = ov7725_vsync & ~vsync_d1;
  assign pix_vld_p0    = (state == ACTIVE) & pix_wr_en & ~vs_rise;
  assign word_vld_p0   = pix_vld_p0 & (lane_cnt == 3'd7);
  // Frame size is a multiple of 8, so the last pixel always closes a word.
  assign frame_last_p0 = pix_vld_p0 & (pix_cnt == PIX_W'(FRAME_PIX - 1));
  assign base_addr     = wr_bank ? BANK1_BASE : BANK0_BASE;

  // vsync edge detector delay flop
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) vsync_d1 <= 1'b0;
    else            vsync_d1 <= ov7725_vsync;
  end

  // FSM state register
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM next-state: every vsync edge (re)starts a frame
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_rise) state_nxt = ACTIVE;
      ACTIVE:  if (vs_rise)            state_nxt = ACTIVE;
               else if (frame_last_p0) state_nxt = DONE;
      DONE:    if (vs_rise) state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane/pixel/word counters; a vsync edge discards any partial word
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lane_cnt <= 3'd0;
      pix_cnt  <= '0;
      word_cnt <= '0;
    end else if (vs_rise) begin
      lane_cnt <= 3'd0;
      pix_cnt  <= '0;
      word_cnt <= '0;
    end else if (pix_vld_p0) begin
      lane_cnt <= lane_cnt + 3'd1;
      pix_cnt  <= pix_cnt + PIX_W'(1);
      // Dropped words still advance the address to keep frame alignment.
      if (lane_cnt == 3'd7) word_cnt <= word_cnt + 1'b1;
    end
  end

  // Packing buffer: lane 0 lands in the top 16 bits
  always_ff @(posedge ov7725_pclk) begin
    if (pix_vld_p0) word_p0[{~lane_cnt, 4'b0000} +: 16] <= pix_data;
  end

  // ---- stage p0 -> FIFO outputs ----
  // Word issue, frame completion and bank swap
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      fifo_wr_addr <= BANK0_BASE;
      frame_done   <= 1'b0;
      rd_bank      <= 1'b1;
      wr_bank      <= 1'b0;
    end else begin
      fifo_wr_en <= word_vld_p0 & ~fifo_full;
      frame_done <= frame_last_p0;
      if (word_vld_p0 & ~fifo_full) begin
        fifo_wr_data <= {word_p0[127:16], pix_data};
        fifo_wr_addr <= base_addr + {word_cnt, 3'b000};
      end
      if (frame_last_p0) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_overflow    <= 1'b0;
      err_short_frame <= 1'b0;
    end else begin
      if (word_vld_p0 & fifo_full) err_overflow <= 1'b1;
      else if (err_clr)            err_overflow <= 1'b0;
      if (vs_rise & (state == ACTIVE) & (pix_cnt != '0)) err_short_frame <= 1'b1;
      else if (err_clr)                                  err_short_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ov7725_ddr_wr_pack.sv
// Scoreboard bench for ov7725_ddr_wr_pack with a 16x2 pixel frame.
module tb_ov7725_ddr_wr_pack;

  localparam int          H_PIX     = 16;
  localparam int          V_LINE    = 2;
  localparam int          ADDR_W    = 28;
  localparam int          FRAME_PIX = H_PIX * V_LINE;
  localparam logic [27:0] B0        = 28'h000_0000;
  localparam logic [27:0] B1        = 28'h005_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vsync = 1'b0;
  logic         pix_wr_en = 1'b0;
  logic [15:0]  pix_data = 16'h0;
  logic         fifo_full = 1'b0;
  logic         err_clr = 1'b0;
  logic         fifo_wr_en;
  logic [127:0] fifo_wr_data;
  logic [27:0]  fifo_wr_addr;
  logic         frame_done;
  logic         rd_bank;
  logic         err_overflow;
  logic         err_short_frame;

  ov7725_ddr_wr_pack #(
    .H_PIX(H_PIX), .V_LINE(V_LINE), .ADDR_W(ADDR_W),
    .BANK0_BASE(B0), .BANK1_BASE(B1)
  ) dut (
    .ov7725_pclk(clk), .sys_rst_n(rst_n), .ov7725_vsync(vsync),
    .pix_wr_en(pix_wr_en), .pix_data(pix_data), .fifo_full(fifo_full),
    .err_clr(err_clr), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_addr(fifo_wr_addr), .frame_done(frame_done), .rd_bank(rd_bank),
    .err_overflow(err_overflow), .err_short_frame(err_short_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [27:0]  addr;
    logic         last;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_bank = 1'b0;
  logic last_bank = 1'b0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Output monitor: strobes are matched against the scoreboard
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (fifo_wr_en) begin
      if (q.size() == 0) begin
        chk("wr_unexpected", 128'(fifo_wr_en), 128'(0));
      end else begin
        e = q.pop_front();
        chk("wr_data", fifo_wr_data, e.data);
        chk("wr_addr", 128'(fifo_wr_addr), 128'(e.addr));
        chk("frame_done", 128'(frame_done), 128'(e.last));
      end
    end else begin
      chk("done_idle", 128'(frame_done), 128'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic vs_pulse(input logic with_pix);
    tick();
    vsync = 1'b1;
    pix_wr_en = with_pix;
    pix_data = 16'hDEAD;
    tick();
    vsync = 1'b0;
    pix_wr_en = 1'b0;
    tick();
  endtask

  task automatic send_pix(input logic [15:0] v);
    tick();
    pix_wr_en = 1'b1;
    pix_data = v;
    tick();
    pix_wr_en = 1'b0;
  endtask

  // Drives npix pixels valued 1..npix; word drop_word is presented with FIFO full.
  task automatic send_frame(input int npix, input int drop_word);
    logic [127:0] w;
    logic [27:0]  base;
    logic [15:0]  v;
    exp_t         e;
    w = '0;
    base = exp_bank ? B1 : B0;
    for (int i = 0; i < npix; i++) begin
      v = 16'(i + 1);
      w = {w[111:0], v};
      if ((i % 8 == 0) && (i / 8 == drop_word)) fifo_full = 1'b1;
      if ((i % 8 == 7) && (i / 8 != drop_word)) begin
        e.data = w;
        e.addr = base + 28'(8 * (i / 8));
        e.last = (i + 1 == FRAME_PIX);
        q.push_back(e);
      end
      send_pix(v);
      if ((i % 8 == 7) && (i / 8 == drop_word)) begin
        tick();
        fifo_full = 1'b0;
      end
    end
    if (npix == FRAME_PIX) begin
      last_bank = exp_bank;
      exp_bank = ~exp_bank;
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    chk(tag, 128'(q.size()), 128'(0));
    q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"}, 128'(fifo_wr_en), 128'(0));
    chk({tag, "_data"}, fifo_wr_data, 128'(0));
    chk({tag, "_addr"}, 128'(fifo_wr_addr), 128'(B0));
    chk({tag, "_done"}, 128'(frame_done), 128'(0));
    chk({tag, "_rd_bank"}, 128'(rd_bank), 128'(1));
    chk({tag, "_ovf"}, 128'(err_overflow), 128'(0));
    chk({tag, "_short"}, 128'(err_short_frame), 128'(0));
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Pixels before any vsync are ignored
    for (int i = 0; i < 8; i++) send_pix(16'h1000 + 16'(i));
    drain("pre_vsync");

    // Frame 1 to bank 0, then stray pixels after completion
    vs_pulse(1'b0);
    send_frame(FRAME_PIX, -1);
    drain("frame1");
    chk("rd_bank_f1", 128'(rd_bank), 128'(last_bank));
    for (int i = 0; i < 8; i++) send_pix(16'h2000 + 16'(i));
    drain("post_done");

    // Frames 2 and 3 alternate banks
    vs_pulse(1'b0);
    send_frame(FRAME_PIX, -1);
    drain("frame2");
    chk("rd_bank_f2", 128'(rd_bank), 128'(last_bank));
    vs_pulse(1'b0);
    send_frame(FRAME_PIX, -1);
    drain("frame3");
    chk("rd_bank_f3", 128'(rd_bank), 128'(last_bank));

    // Overflow on the second word
    vs_pulse(1'b0);
    send_frame(FRAME_PIX, 1);
    drain("overflow");
    chk("rd_bank_f4", 128'(rd_bank), 128'(last_bank));
    chk("err_ovf_set", 128'(err_overflow), 128'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("err_ovf_clr", 128'(err_overflow), 128'(0));

    // Short frame: 13 pixels then a new vsync
    vs_pulse(1'b0);
    send_frame(13, -1);
    drain("short_part");
    chk("err_short_pre", 128'(err_short_frame), 128'(0));
    vs_pulse(1'b0);
    chk("err_short_set", 128'(err_short_frame), 128'(1));
    send_frame(FRAME_PIX, -1);
    drain("after_short");
    chk("rd_bank_f5", 128'(rd_bank), 128'(last_bank));

    // Pixel coincident with vsync edge is dropped
    vs_pulse(1'b1);
    send_frame(FRAME_PIX, -1);
    drain("coincident");
    chk("rd_bank_f6", 128'(rd_bank), 128'(last_bank));

    // Asynchronous reset mid-word
    vs_pulse(1'b0);
    send_frame(5, -1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst_n = 1'b1;
    exp_bank = 1'b0;
    for (int i = 0; i < 8; i++) send_pix(16'h3000 + 16'(i));
    drain("post_rst");
    vs_pulse(1'b0);
    send_frame(FRAME_PIX, -1);
    drain("frame_rst");
    chk("rd_bank_f7", 128'(rd_bank), 128'(last_bank));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
